// File: rtl/reel_spin_sequencer.sv
// Spin timer for the slot-machine game path: starts all reels together, stops them
// on a staggered tick schedule or on player request, and raises compute when the last stops.
module reel_spin_sequencer #(
    parameter int NUM_REELS     = 3,
    parameter int CNT_WIDTH     = 8,
    parameter int BASE_TICKS    = 5,
    parameter int STAGGER_TICKS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_game,
    input  logic                 tick_en,
    input  logic                 stop_req,
    output logic                 hold,
    output logic [NUM_REELS-1:0] spinning,
    output logic                 compute,
    output logic                 done_pulse,
    output logic [CNT_WIDTH-1:0] tick_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPIN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] tick_inc;
    logic [CNT_WIDTH-1:0] tick_next;
    logic [NUM_REELS-1:0] sched_clear;
    logic [NUM_REELS-1:0] stop_mask;
    logic [NUM_REELS-1:0] spin_next;

    // NOTE: every signal driven here gets a default before any branch, so no latch is inferred.
    always_comb begin
        tick_inc    = tick_count + CNT_WIDTH'(1);
        tick_next   = tick_en ? tick_inc : tick_count;
        sched_clear = '0;
        for (int i = 0; i < NUM_REELS; i++) begin
            sched_clear[i] = tick_en && (tick_inc == CNT_WIDTH'(BASE_TICKS + i * STAGGER_TICKS));
        end
        // Two's-complement trick isolates the lowest reel still spinning.
        stop_mask = stop_req ? (spinning & (~spinning + NUM_REELS'(1))) : '0;
        spin_next = spinning & ~(sched_clear | stop_mask);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hold       <= 1'b0;
            spinning   <= '0;
            compute    <= 1'b0;
            done_pulse <= 1'b0;
            tick_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run_game) begin
                        state      <= SPIN;
                        hold       <= 1'b1;
                        spinning   <= '1;
                        tick_count <= '0;
                    end
                end
                SPIN: begin
                    // Abort outranks both the tick and a player stop on the same edge.
                    if (!run_game) begin
                        state      <= IDLE;
                        hold       <= 1'b0;
                        spinning   <= '0;
                        tick_count <= '0;
                    end else begin
                        tick_count <= tick_next;
                        spinning   <= spin_next;
                        if (spin_next == '0) begin
                            state      <= DONE;
                            compute    <= 1'b1;
                            done_pulse <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_pulse <= 1'b0;
                    if (!run_game) begin
                        state      <= IDLE;
                        hold       <= 1'b0;
                        spinning   <= '0;
                        compute    <= 1'b0;
                        tick_count <= '0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    hold       <= 1'b0;
                    spinning   <= '0;
                    compute    <= 1'b0;
                    done_pulse <= 1'b0;
                    tick_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reel_spin_sequencer.sv
// Directed bench for reel_spin_sequencer at default parameters (3 reels, stops at ticks 5/8/11).
module tb_reel_spin_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       run_game;
    logic       tick_en;
    logic       stop_req;
    logic       hold;
    logic [2:0] spinning;
    logic       compute;
    logic       done_pulse;
    logic [7:0] tick_count;

    int vectors     = 0;
    int miscompares = 0;

    reel_spin_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .run_game   (run_game),
        .tick_en    (tick_en),
        .stop_req   (stop_req),
        .hold       (hold),
        .spinning   (spinning),
        .compute    (compute),
        .done_pulse (done_pulse),
        .tick_count (tick_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".hold"}, 32'(hold), 32'd0);
        check({tag, ".spinning"}, 32'(spinning), 32'd0);
        check({tag, ".compute"}, 32'(compute), 32'd0);
        check({tag, ".done_pulse"}, 32'(done_pulse), 32'd0);
        check({tag, ".tick_count"}, 32'(tick_count), 32'd0);
    endtask

    // Reels stop at ticks 5, 8, 11 with the default schedule.
    function automatic logic [2:0] sched_spin(input int n);
        if (n >= 11) return 3'b000;
        if (n >= 8)  return 3'b100;
        if (n >= 5)  return 3'b110;
        return 3'b111;
    endfunction

    initial begin
        int n;
        int pulses;
        logic [2:0] exp_spin;

        rst = 1'b1; run_game = 1'b0; tick_en = 1'b0; stop_req = 1'b0;
        #2;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;
        step();
        check_idle("idle_no_run");

        // Round 1: free-running ticks, scheduled stops only.
        run_game = 1'b1; tick_en = 1'b1;
        step();
        check("r1_e0.hold", 32'(hold), 32'd1);
        check("r1_e0.spinning", 32'(spinning), 32'h7);
        check("r1_e0.tick_count", 32'(tick_count), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("r1_e%0d.spinning", k), 32'(spinning), 32'(sched_spin(k)));
            check($sformatf("r1_e%0d.compute", k), 32'(compute), 32'(k >= 11));
            check($sformatf("r1_e%0d.done_pulse", k), 32'(done_pulse), 32'(k == 11));
            check($sformatf("r1_e%0d.hold", k), 32'(hold), 32'd1);
            check($sformatf("r1_e%0d.tick_count", k), 32'(tick_count), 32'((k < 11) ? k : 11));
        end
        run_game = 1'b0;
        step();
        check_idle("r1_drop");

        // Round 2: tick_en every 4th cycle.
        run_game = 1'b1; tick_en = 1'b0;
        step();
        n = 0;
        for (int c = 1; c <= 52; c++) begin
            tick_en = (c % 4 == 0);
            if (tick_en && n < 11) n++;
            step();
            check($sformatf("r2_c%0d.spinning", c), 32'(spinning), 32'(sched_spin(n)));
            check($sformatf("r2_c%0d.compute", c), 32'(compute), 32'(n >= 11));
        end
        check("r2_done.tick_count", 32'(tick_count), 32'd11);
        tick_en = 1'b1; run_game = 1'b0;
        step();
        check_idle("r2_drop");

        // Round 3: player stops at E2, E3 and at E11 together with reel 2's schedule.
        run_game = 1'b1;
        step();
        pulses = 0;
        for (int k = 1; k <= 13; k++) begin
            stop_req = (k == 2 || k == 3 || k == 11);
            step();
            if (k < 2)       exp_spin = 3'b111;
            else if (k == 2) exp_spin = 3'b110;
            else if (k < 11) exp_spin = 3'b100;
            else             exp_spin = 3'b000;
            if (done_pulse) pulses++;
            check($sformatf("r3_e%0d.spinning", k), 32'(spinning), 32'(exp_spin));
            check($sformatf("r3_e%0d.compute", k), 32'(compute), 32'(k >= 11));
        end
        stop_req = 1'b0;
        check("r3.done_pulse_count", 32'(pulses), 32'd1);
        run_game = 1'b0;
        step();
        check_idle("r3_drop");

        // Round 4: stop_req coinciding with reel 0's scheduled stop.
        run_game = 1'b1;
        step();
        for (int k = 1; k <= 8; k++) begin
            stop_req = (k == 5);
            step();
            check($sformatf("r4_e%0d.spinning", k), 32'(spinning), 32'(sched_spin(k)));
        end
        stop_req = 1'b0; run_game = 1'b0;
        step();
        check_idle("r4_drop");

        // Round 5: abort at E7, then restart.
        run_game = 1'b1;
        step();
        for (int k = 1; k <= 6; k++) step();
        check("r5_e6.spinning", 32'(spinning), 32'h6);
        run_game = 1'b0;
        step();
        check_idle("r5_abort");
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("r5_idle%0d.compute", k), 32'(compute), 32'd0);
            check($sformatf("r5_idle%0d.done_pulse", k), 32'(done_pulse), 32'd0);
        end
        run_game = 1'b1;
        step();
        check("r5_restart.hold", 32'(hold), 32'd1);
        check("r5_restart.spinning", 32'(spinning), 32'h7);
        check("r5_restart.tick_count", 32'(tick_count), 32'd0);
        step(); step(); step();
        check("r5_e3.tick_count", 32'(tick_count), 32'd3);

        // Asynchronous reset mid-spin, between edges.
        #2 rst = 1'b1;
        #1;
        check_idle("async_rst");
        #1 rst = 1'b0;
        step();
        check("post_rst.hold", 32'(hold), 32'd1);
        check("post_rst.spinning", 32'(spinning), 32'h7);
        check("post_rst.tick_count", 32'(tick_count), 32'd0);
        step();
        check("post_rst_e1.tick_count", 32'(tick_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
